// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a first-word-fall-through TX FIFO onto a UART line
// (1 start bit, NBIT data bits LSB first, 1 stop bit) using an internal 16x baud tick.
module fifo_uart_tx #(
    parameter int NBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR    = 163
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            fifo_empty,
    input  logic [NBIT-1:0] fifo_dout,
    output logic            rd_fifo,
    output logic            tx,
    output logic            tx_busy,
    output logic            tick_o
);
    localparam int BW = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam int NW = (NBIT > 1) ? $clog2(NBIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(DVSR - 1);
    localparam logic [4:0]    S_LAST    = 5'd15;
    localparam logic [4:0]    STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST    = NW'(NBIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          r_state, w_state_next;
    logic [BW-1:0]   r_baud;
    logic [4:0]      r_s, w_s_next;
    logic [NW-1:0]   r_n, w_n_next;
    logic [NBIT-1:0] r_b, w_b_next;
    logic            r_tx, w_tx_next;
    logic            w_tick, w_pop;

    assign w_tick = (r_baud == BAUD_LAST);
    // Reset beats a waiting byte: no pop is issued while RESET is high.
    assign w_pop  = (r_state == IDLE) && !fifo_empty && !RESET;

    // Restarting the baud counter at the pop makes every frame start on a fixed phase.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_baud <= '0;
        end else if (w_pop || w_tick) begin
            r_baud <= '0;
        end else begin
            r_baud <= r_baud + 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_s_next     = r_s;
        w_n_next     = r_n;
        w_b_next     = r_b;
        case (r_state)
            IDLE: begin
                if (w_pop) begin
                    w_b_next     = fifo_dout;
                    w_s_next     = '0;
                    w_state_next = START;
                end
            end
            START: begin
                if (w_tick) begin
                    if (r_s == S_LAST) begin
                        w_s_next     = '0;
                        w_n_next     = '0;
                        w_state_next = DATA;
                    end else begin
                        w_s_next = r_s + 5'd1;
                    end
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_s == S_LAST) begin
                        w_s_next = '0;
                        w_b_next = r_b >> 1;
                        if (r_n == N_LAST) begin
                            w_state_next = STOP;
                        end else begin
                            w_n_next = r_n + 1'b1;
                        end
                    end else begin
                        w_s_next = r_s + 5'd1;
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (r_s == STOP_LAST) begin
                        w_s_next     = '0;
                        w_state_next = IDLE;
                    end else begin
                        w_s_next = r_s + 5'd1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase

        // The line level is derived from the next state so tx is a clean register output.
        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_b_next[0];
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_s     <= w_s_next;
            r_n     <= w_n_next;
            r_b     <= w_b_next;
            r_tx    <= w_tx_next;
        end
    end

    assign rd_fifo = w_pop;
    assign tx      = r_tx;
    assign tx_busy = (r_state != IDLE);
    assign tick_o  = w_tick;

endmodule
